// File: rtl/lz77_stream_encoder.sv
// Streaming LZ77 tokeniser: one symbol in per handshake, one (len, dist-1, literal, last) token out.
// Token registers on the edge that accepts its terminating symbol; input stalls while an undrained token is held.
module lz77_stream_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int DICT_DEPTH = 512,
  parameter int DICT_LOG   = 9,
  parameter int MAX_LEN    = 65,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LEN_WIDTH-1:0]  out_len,
  output logic [DICT_LOG-1:0]   out_dist,
  output logic [DATA_WIDTH-1:0] out_literal,
  output logic                  out_last
);

  logic [DATA_WIDTH-1:0] dict [DICT_DEPTH];
  logic [DICT_DEPTH-1:0] dict_vld;
  logic [DICT_DEPTH-1:0] cand;
  logic [DICT_DEPTH-1:0] hit;
  logic [LEN_WIDTH-1:0]  len;
  logic [DICT_LOG-1:0]   dsel;
  logic [DICT_LOG-1:0]   hit_idx;
  logic                  accept;
  logic                  ext;
  logic                  extend;
  logic                  emit;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Candidates are indexed by distance, so they stay put while the history shifts.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DICT_DEPTH; i++) begin
      hit[i] = dict_vld[i] && (dict[i] == in_data) && ((len == '0) || cand[i]);
    end
  end

  // Lowest index wins: the most recent occurrence.
  always_comb begin
    hit_idx = '0;
    for (int i = DICT_DEPTH - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = DICT_LOG'(i);
    end
  end

  assign ext    = |hit;
  assign extend = accept && ext && !in_last && (len < LEN_WIDTH'(MAX_LEN));
  assign emit   = accept && !extend;

  always_ff @(posedge clk) begin
    if (accept) begin
      dict[0] <= in_data;
      for (int i = 1; i < DICT_DEPTH; i++) dict[i] <= dict[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dict_vld    <= '0;
      cand        <= '1;
      len         <= '0;
      dsel        <= '0;
      out_valid   <= 1'b0;
      out_len     <= '0;
      out_dist    <= '0;
      out_literal <= '0;
      out_last    <= 1'b0;
    end else begin
      if (accept) begin
        // A stream's final token wipes the history so the next stream starts clean.
        if (emit && in_last) dict_vld <= '0;
        else                 dict_vld <= {dict_vld[DICT_DEPTH-2:0], 1'b1};
        if (extend) begin
          len  <= len + 1'b1;
          cand <= hit;
          dsel <= hit_idx;
        end else begin
          len  <= '0;
          cand <= '1;
          dsel <= '0;
        end
      end
      if (emit) begin
        out_valid   <= 1'b1;
        out_len     <= len;
        out_dist    <= (len == '0) ? '0 : dsel;
        out_literal <= in_data;
        out_last    <= in_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lz77_stream_encoder.sv
// Directed bench for lz77_stream_encoder: hand-computed token sequences checked with immediate assertions.
module tb_lz77_stream_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_len;
  logic [8:0] out_dist;
  logic [7:0] out_literal;
  logic       out_last;

  int errors = 0;
  int checks = 0;
  logic [24:0] tokq [$];

  lz77_stream_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_len(out_len),
    .out_dist(out_dist), .out_literal(out_literal), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      tokq.push_back({out_len, out_dist, out_literal, out_last});
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input logic last_at_end);
    for (int i = 0; i < s.len(); i++)
      send(s[i], last_at_end && (i == s.len() - 1));
  endtask

  task automatic expect_tok(input int l, input int d, input logic [7:0] c, input logic la,
                            input string tag);
    logic [24:0] exp;
    logic [24:0] got;
    int n;
    n = 0;
    exp = {7'(l), 9'(d), c, la};
    while (tokq.size() == 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (tokq.size() == 0) got = 'x;
    else                  got = tokq.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got len=%0d dist=%0d lit=%h last=%b, expected len=%0d dist=%0d lit=%h last=%b",
             tag, got[24:18], got[17:9], got[8:1], got[0], exp[24:18], exp[17:9], exp[8:1], exp[0]);
    end
  endtask

  task automatic check_bit(input logic got, input logic exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic check_val(input int got, input int exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit(out_valid, 1'b0, "reset_out_valid");
    check_bit(in_ready, 1'b1, "reset_in_ready");
    check_val(int'(out_len), 0, "reset_out_len");
    check_val(int'(out_dist), 0, "reset_out_dist");
    check_val(int'(out_literal), 0, "reset_out_literal");
    check_bit(out_last, 1'b0, "reset_out_last");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset in the middle of a stream
    send_str("ab", 1'b0);
    expect_tok(0, 0, "a", 1'b0, "mid_a");
    expect_tok(0, 0, "b", 1'b0, "mid_b");
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_bit(out_valid, 1'b0, "midreset_out_valid");
    check_bit(in_ready, 1'b1, "midreset_in_ready");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tokq.delete();
    send_str("a", 1'b1);
    expect_tok(0, 0, "a", 1'b1, "after_reset_a");

    // Repeating pattern with overlapping match
    send_str("abcabcabcX", 1'b1);
    expect_tok(0, 0, "a", 1'b0, "abc_t0");
    expect_tok(0, 0, "b", 1'b0, "abc_t1");
    expect_tok(0, 0, "c", 1'b0, "abc_t2");
    expect_tok(6, 2, "X", 1'b1, "abc_t3");

    // Length saturation
    for (int i = 0; i < 68; i++) send("A", i == 67);
    expect_tok(0, 0, "A", 1'b0, "sat_t0");
    expect_tok(65, 0, "A", 1'b0, "sat_t1");
    expect_tok(0, 0, "A", 1'b1, "sat_t2");

    // Smallest distance wins
    send_str("aXaYaZ", 1'b1);
    expect_tok(0, 0, "a", 1'b0, "tie_t0");
    expect_tok(0, 0, "X", 1'b0, "tie_t1");
    expect_tok(1, 1, "Y", 1'b0, "tie_t2");
    expect_tok(1, 1, "Z", 1'b1, "tie_t3");

    // Restart: history must not leak across streams
    send_str("ab", 1'b1);
    send_str("ab", 1'b1);
    expect_tok(0, 0, "a", 1'b0, "rs1_a");
    expect_tok(0, 0, "b", 1'b1, "rs1_b");
    expect_tok(0, 0, "a", 1'b0, "rs2_a");
    expect_tok(0, 0, "b", 1'b1, "rs2_b");

    // Backpressure hold
    out_ready = 1'b0;
    send("p", 1'b0);
    in_valid = 1'b1;
    in_data  = "q";
    in_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_bit(in_ready, 1'b0, "bp_in_ready");
      check_bit(out_valid, 1'b1, "bp_out_valid");
      check_val(int'({out_len, out_dist, out_literal, out_last}),
                int'({7'd0, 9'd0, 8'h70, 1'b0}), "bp_token_stable");
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_bit(in_ready, 1'b1, "bp_release_ready");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send("r", 1'b1);
    expect_tok(0, 0, "p", 1'b0, "bp_p");
    expect_tok(0, 0, "q", 1'b0, "bp_q");
    expect_tok(0, 0, "r", 1'b1, "bp_r");

    repeat (5) @(posedge clk);
    #1;
    check_val(tokq.size(), 0, "no_extra_tokens");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
